// File: rtl/serial_parity_checker.sv
// Serial even-parity frame receiver: DATA_W data bits LSB first plus one parity bit,
// framed by sof, with abort detection and a saturating parity-error counter.
module serial_parity_checker #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_valid,
    input  logic              bit_in,
    input  logic              sof,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    output logic              parity_err,
    output logic              frame_abort,
    output logic [CNT_W-1:0]  err_count,
    output logic              busy
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                par_q, par_d;
    logic [DATA_W-1:0]   buf_q, buf_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic                out_valid_q, out_valid_d;
    logic                parity_err_q, parity_err_d;
    logic                frame_abort_q, frame_abort_d;
    logic [CNT_W-1:0]    err_count_q, err_count_d;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        par_d         = par_q;
        buf_d         = buf_q;
        data_out_d    = data_out_q;
        parity_err_d  = parity_err_q;
        out_valid_d   = 1'b0;
        frame_abort_d = 1'b0;
        err_count_d   = err_count_q;

        if (bit_valid) begin
            if (sof) begin
                // sof always restarts a frame; a frame already in flight is dropped
                frame_abort_d = (state_q != IDLE);
                buf_d[0]      = bit_in;
                par_d         = bit_in;
                idx_d         = (DATA_W == 1) ? '0 : IDX_W'(1);
                state_d       = (DATA_W == 1) ? PARITY : DATA;
            end else begin
                case (state_q)
                    DATA: begin
                        buf_d[idx_q] = bit_in;
                        par_d        = par_q ^ bit_in;
                        if (idx_q == LAST_IDX) begin
                            idx_d   = '0;
                            state_d = PARITY;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                    PARITY: begin
                        out_valid_d  = 1'b1;
                        data_out_d   = buf_q;
                        parity_err_d = par_q ^ bit_in;
                        par_d        = 1'b0;
                        idx_d        = '0;
                        state_d      = IDLE;
                    end
                    default: ;
                endcase
            end
        end

        // counter updates together with out_valid so it already reflects this frame
        if (out_valid_d && parity_err_d && (err_count_q != '1))
            err_count_d = err_count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            par_q         <= 1'b0;
            buf_q         <= '0;
            data_out_q    <= '0;
            out_valid_q   <= 1'b0;
            parity_err_q  <= 1'b0;
            frame_abort_q <= 1'b0;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            par_q         <= par_d;
            buf_q         <= buf_d;
            data_out_q    <= data_out_d;
            out_valid_q   <= out_valid_d;
            parity_err_q  <= parity_err_d;
            frame_abort_q <= frame_abort_d;
            err_count_q   <= err_count_d;
        end
    end

    assign data_out    = data_out_q;
    assign out_valid   = out_valid_q;
    assign parity_err  = parity_err_q;
    assign frame_abort = frame_abort_q;
    assign err_count   = err_count_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_serial_parity_checker.sv
// Scoreboard bench for serial_parity_checker: two instances (CNT_W=8 and CNT_W=2)
// share stimulus; a frame-level model predicts results, a monitor checks them.
module tb_serial_parity_checker;

    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic bit_valid = 1'b0;
    logic bit_in = 1'b0;
    logic sof = 1'b0;

    logic [DW-1:0] data_out_a, data_out_b;
    logic          out_valid_a, out_valid_b;
    logic          parity_err_a, parity_err_b;
    logic          frame_abort_a, frame_abort_b;
    logic [7:0]    err_count_a;
    logic [1:0]    err_count_b;
    logic          busy_a, busy_b;

    serial_parity_checker #(.DATA_W(DW), .CNT_W(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_in(bit_in), .sof(sof),
        .data_out(data_out_a), .out_valid(out_valid_a), .parity_err(parity_err_a),
        .frame_abort(frame_abort_a), .err_count(err_count_a), .busy(busy_a)
    );

    serial_parity_checker #(.DATA_W(DW), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_in(bit_in), .sof(sof),
        .data_out(data_out_b), .out_valid(out_valid_b), .parity_err(parity_err_b),
        .frame_abort(frame_abort_b), .err_count(err_count_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        int            cnt_a;
        int            cnt_b;
    } exp_t;

    exp_t exp_q[$];
    int   exp_abort;
    bit   cur[$];
    int   model_cnt_a, model_cnt_b;
    bit   model_busy;
    logic [DW-1:0] hold_data;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Frame-level reference: collect bits of the current frame, judge when complete.
    task automatic model_step(input bit v, input bit s, input bit b);
        exp_t e;
        int ones;
        if (!v) return;
        if (s) begin
            if (cur.size() > 0) exp_abort++;
            cur.delete();
            cur.push_back(b);
        end else if (cur.size() > 0) begin
            cur.push_back(b);
        end
        if (cur.size() == DW + 1) begin
            e.data = '0;
            for (int i = 0; i < DW; i++) e.data[i] = cur[i];
            ones = $countones(e.data) + int'(cur[DW]);
            e.err = (ones % 2) != 0;
            if (e.err) begin
                if (model_cnt_a < 255) model_cnt_a++;
                if (model_cnt_b < 3) model_cnt_b++;
            end
            e.cnt_a = model_cnt_a;
            e.cnt_b = model_cnt_b;
            exp_q.push_back(e);
            cur.delete();
        end
        model_busy = cur.size() > 0;
    endtask

    task automatic drive(input bit v, input bit s, input bit b);
        @(negedge clk);
        bit_valid = v;
        sof = s;
        bit_in = b;
        @(posedge clk);
        model_step(v, s, b);
    endtask

    // Idle cycles carry junk on sof/bit_in, which must be ignored.
    task automatic gap(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom), 1'($urandom));
    endtask

    // Sends the first nbits of the frame (DW+1 = complete frame).
    task automatic send_frame(input logic [DW-1:0] w, input bit pbit, input int gmax, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            if (i > 0) gap(gmax < 0 ? -gmax : $urandom_range(gmax, 0));
            drive(1'b1, i == 0, i < DW ? w[i] : pbit);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        bit_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_data_out", data_out_a, 0);
        chk("rst_out_valid", out_valid_a, 0);
        chk("rst_parity_err", parity_err_a, 0);
        chk("rst_frame_abort", frame_abort_a, 0);
        chk("rst_err_count", err_count_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_err_count_b", err_count_b, 0);
        chk("rst_busy_b", busy_b, 0);
        cur.delete();
        exp_q.delete();
        exp_abort = 0;
        model_busy = 0;
        model_cnt_a = 0;
        model_cnt_b = 0;
        hold_data = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: compare presented outputs against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("busy", busy_a, model_busy);
                chk("busy_b", busy_b, model_busy);
                if (out_valid_a) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_out_valid", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("data_out", data_out_a, e.data);
                        chk("parity_err", parity_err_a, e.err);
                        chk("err_count", err_count_a, e.cnt_a);
                        chk("data_out_b", data_out_b, e.data);
                        chk("err_count_b", err_count_b, e.cnt_b);
                        hold_data = e.data;
                    end
                end else begin
                    chk("data_out_hold", data_out_a, hold_data);
                end
                chk("out_valid_b", out_valid_b, out_valid_a);
                if (frame_abort_a) begin
                    chk("unexpected_abort", exp_abort > 0, 1);
                    if (exp_abort > 0) exp_abort--;
                end
                chk("frame_abort_b", frame_abort_b, frame_abort_a);
            end
        end
    end

    task automatic drain(input string name);
        gap(3);
        chk({name, "_pending_frames"}, exp_q.size(), 0);
        chk({name, "_pending_aborts"}, exp_abort, 0);
    endtask

    initial begin
        exp_abort = 0;
        model_cnt_a = 0;
        model_cnt_b = 0;
        model_busy = 0;
        hold_data = '0;
        do_reset();
        gap(2);

        // 0xA5 good parity
        send_frame(8'hA5, 1'b0, 0, DW + 1);
        drain("a5");
        // 0x07 with parity 1 (good) then parity 0 (bad)
        send_frame(8'h07, 1'b1, 0, DW + 1);
        send_frame(8'h07, 1'b0, 0, DW + 1);
        drain("x07");
        // 0x3C with 5 idle cycles between every bit
        send_frame(8'h3C, 1'b0, -5, DW + 1);
        drain("x3c");
        // sof where data bit 4 would be, then 0x81
        send_frame(8'h5A, 1'b0, 0, 4);
        send_frame(8'h81, 1'b0, 0, DW + 1);
        drain("abort");

        // four bad frames back-to-back; CNT_W=2 instance saturates at 3
        do_reset();
        for (int k = 0; k < 4; k++) send_frame(8'h01 << k, 1'b0, 0, DW + 1);
        drain("b2b");
        chk("sat_count_b", err_count_b, 3);
        chk("count_a_four", err_count_a, 4);

        // reset while in PARITY, stray bits, then 0xFF
        send_frame(8'h12, 1'b0, 0, DW);
        do_reset();
        for (int k = 0; k < 4; k++) drive(1'b1, 1'b0, 1'($urandom));
        send_frame(8'hFF, 1'b0, 0, DW + 1);
        drain("post_reset");

        // randomized frames: random data/parity, gaps, truncations, stray bits
        for (int n = 0; n < 150; n++) begin
            int nb;
            nb = ($urandom_range(7, 0) == 0) ? $urandom_range(DW, 1) : DW + 1;
            if ($urandom_range(9, 0) == 0) drive(1'b1, 1'b0, 1'($urandom));
            send_frame(DW'($urandom), 1'($urandom), $urandom_range(2, 0), nb);
            if ($urandom_range(3, 0) == 0) gap($urandom_range(3, 0));
        end
        send_frame(8'hC3, 1'b0, 0, DW + 1);
        drain("random");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
